// File: rtl/systolic_tile_sequencer_if.sv
// Handshake and data bundle between the tile sequencer, its controller,
// the systolic array and the A/B/C tile buffers.
interface systolic_tile_sequencer_if #(
  parameter int unsigned SYS_ARR_SIZE    = 2,
  parameter int unsigned DATA_PRECISION  = 16,
  parameter int unsigned BRAM_ADDR_WIDTH = 10,
  parameter int unsigned K_WIDTH         = 16
);
  logic                                             start_i;
  logic [K_WIDTH-1:0]                               k_len_i;
  logic [BRAM_ADDR_WIDTH-1:0]                       a_base_i;
  logic [BRAM_ADDR_WIDTH-1:0]                       b_base_i;
  logic [BRAM_ADDR_WIDTH-1:0]                       c_base_i;
  logic [BRAM_ADDR_WIDTH-1:0]                       a_addr_o;
  logic [BRAM_ADDR_WIDTH-1:0]                       b_addr_o;
  logic                                             ab_en_o;
  logic                                             sys_valid_o;
  logic [SYS_ARR_SIZE*SYS_ARR_SIZE*DATA_PRECISION-1:0] sys_output_i;
  logic                                             sys_output_valid_i;
  logic                                             acc_clear_o;
  logic [BRAM_ADDR_WIDTH-1:0]                       c_addr_o;
  logic [SYS_ARR_SIZE*DATA_PRECISION-1:0]           c_data_o;
  logic                                             c_we_o;
  logic                                             c_ready_i;
  logic                                             busy_o;
  logic                                             done_o;
  logic                                             timeout_o;

  modport master (
    input  start_i, k_len_i, a_base_i, b_base_i, c_base_i,
    input  sys_output_i, sys_output_valid_i, c_ready_i,
    output a_addr_o, b_addr_o, ab_en_o, sys_valid_o, acc_clear_o,
    output c_addr_o, c_data_o, c_we_o, busy_o, done_o, timeout_o
  );

  modport slave (
    output start_i, k_len_i, a_base_i, b_base_i, c_base_i,
    output sys_output_i, sys_output_valid_i, c_ready_i,
    input  a_addr_o, b_addr_o, ab_en_o, sys_valid_o, acc_clear_o,
    input  c_addr_o, c_data_o, c_we_o, busy_o, done_o, timeout_o
  );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Sequences one output tile: feed K operand vectors, wait for the array
// result, write the result rows to the C buffer, then clear the accumulators.
module systolic_tile_sequencer #(
  parameter int unsigned SYS_ARR_SIZE    = 2,
  parameter int unsigned DATA_PRECISION  = 16,
  parameter int unsigned BRAM_ADDR_WIDTH = 10,
  parameter int unsigned K_WIDTH         = 16,
  parameter int unsigned DRAIN_TIMEOUT   = 64
) (
  input logic                           clk_i,
  input logic                           rst_i,
  systolic_tile_sequencer_if.master     bus
);
  localparam int unsigned ROW_W = (SYS_ARR_SIZE > 1) ? $clog2(SYS_ARR_SIZE) : 1;
  localparam int unsigned RW    = SYS_ARR_SIZE * DATA_PRECISION;
  localparam logic [K_WIDTH-1:0] DRAIN_LAST = K_WIDTH'(DRAIN_TIMEOUT - 1);
  localparam logic [K_WIDTH-1:0] ROW_LAST   = K_WIDTH'(SYS_ARR_SIZE - 1);

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, WRITE, CLEAR, DONE} state_t;

  state_t                     state, state_next;
  logic [K_WIDTH-1:0]         cnt, cnt_inc;
  logic [K_WIDTH-1:0]         k_len_q;
  logic [BRAM_ADDR_WIDTH-1:0] a_base_q, b_base_q, c_base_q;
  logic [0:SYS_ARR_SIZE-1][RW-1:0] tile_q;  // index 0 = row 0 = MSBs
  logic                       sys_valid_q;
  logic                       timeout_q;

  assign cnt_inc = cnt + K_WIDTH'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.start_i) state_next = (bus.k_len_i == '0) ? DONE : FEED;
      FEED:  if (cnt_inc == k_len_q) state_next = FLUSH;
      FLUSH: state_next = DRAIN;
      DRAIN: begin
        if (bus.sys_output_valid_i) state_next = WRITE;
        else if (cnt == DRAIN_LAST) state_next = CLEAR;
      end
      WRITE: if (bus.c_ready_i && cnt == ROW_LAST) state_next = CLEAR;
      CLEAR: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.ab_en_o     = 1'b0;
    bus.a_addr_o    = '0;
    bus.b_addr_o    = '0;
    bus.c_we_o      = 1'b0;
    bus.c_addr_o    = '0;
    bus.c_data_o    = '0;
    bus.acc_clear_o = 1'b0;
    bus.done_o      = 1'b0;
    bus.busy_o      = (state != IDLE);
    bus.sys_valid_o = sys_valid_q;
    bus.timeout_o   = timeout_q;
    unique case (state)
      FEED: begin
        bus.ab_en_o  = 1'b1;
        bus.a_addr_o = a_base_q + BRAM_ADDR_WIDTH'(cnt);
        bus.b_addr_o = b_base_q + BRAM_ADDR_WIDTH'(cnt);
      end
      WRITE: begin
        bus.c_we_o   = 1'b1;
        bus.c_addr_o = c_base_q + BRAM_ADDR_WIDTH'(cnt);
        bus.c_data_o = tile_q[ROW_W'(cnt)];
      end
      CLEAR: bus.acc_clear_o = 1'b1;
      DONE:  bus.done_o      = 1'b1;
      default: ;
    endcase
  end

  // cnt is shared: feed index in FEED, wait cycles in DRAIN, row index in WRITE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      k_len_q     <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
      tile_q      <= '0;
      sys_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sys_valid_q <= (state == FEED);
      if (state == IDLE && bus.start_i) begin
        k_len_q   <= bus.k_len_i;
        a_base_q  <= bus.a_base_i;
        b_base_q  <= bus.b_base_i;
        c_base_q  <= bus.c_base_i;
        timeout_q <= 1'b0;
      end
      if (state == DRAIN && bus.sys_output_valid_i) tile_q <= bus.sys_output_i;
      if (state == DRAIN && state_next == CLEAR) timeout_q <= 1'b1;
      if (state_next != state)                    cnt <= '0;
      else if (state == FEED || state == DRAIN)   cnt <= cnt_inc;
      else if (state == WRITE && bus.c_ready_i)   cnt <= cnt_inc;
    end
  end
endmodule

// File: doc/systolic_tile_sequencer.md
Name: systolic_tile_sequencer

Overview:
Sequences one output tile of the SYS_ARR_SIZE x SYS_ARR_SIZE systolic array. After a start command it streams K operand vectors from the A and B tile BRAMs into the array and waits for the array outputs to become valid. It then writes the result rows to the C buffer and clears the array accumulators. It sits between accelerator_ctl, which issues start/k_len/base addresses, and the systolic_array plus its tile BRAMs.

Parameters:
SYS_ARR_SIZE, 2, array rows = cols
DATA_PRECISION, 16, bits per element
BRAM_ADDR_WIDTH, 10, A/B/C buffer address width
K_WIDTH, 16, width of reduction-length field
DRAIN_TIMEOUT, 64, max cycles waiting for array output valid

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  one-cycle start pulse; sampled only in IDLE
k_len_i  in  K_WIDTH  reduction length (vectors to feed)
a_base_i  in  BRAM_ADDR_WIDTH  first A vector address
b_base_i  in  BRAM_ADDR_WIDTH  first B vector address
c_base_i  in  BRAM_ADDR_WIDTH  first C row address
a_addr_o  out  BRAM_ADDR_WIDTH  A BRAM read address
b_addr_o  out  BRAM_ADDR_WIDTH  B BRAM read address
ab_en_o  out  1  A/B BRAM read enable (1-cycle read latency)
sys_valid_o  out  1  input/weight valid to array
sys_output_i  in  SYS_ARR_SIZE*SYS_ARR_SIZE*DATA_PRECISION  flattened array outputs, row 0 in MSBs
sys_output_valid_i  in  1  AND of all PE output valids
acc_clear_o  out  1  one-cycle accumulator clear to array
c_addr_o  out  BRAM_ADDR_WIDTH  C write address
c_data_o  out  SYS_ARR_SIZE*DATA_PRECISION  one result row
c_we_o  out  1  C write request
c_ready_i  in  1  C buffer accepts write when c_we_o & c_ready_i
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle completion pulse
timeout_o  out  1  sticky drain-timeout error, cleared by next accepted start

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0, including addresses, c_data_o, timeout_o and counters.
- States: IDLE, FEED, FLUSH, DRAIN, WRITE, CLEAR, DONE.
- IDLE: on start_i, latch k_len, a_base, b_base, c_base; clear timeout_o. If k_len=0, go to DONE with no BRAM reads, array activity or C writes. Otherwise go to FEED. start_i is ignored in every other state.
- FEED: ab_en_o=1 for exactly k_len consecutive cycles. a_addr_o and b_addr_o take base+i for i=0..k_len-1, wrapping modulo 2^BRAM_ADDR_WIDTH. After the last read, go to FLUSH.
- sys_valid_o is ab_en_o delayed 1 cycle, so it aligns with BRAM read data. It is high for exactly k_len cycles, with the first assertion one cycle after entering FEED.
- FLUSH: single cycle covering the final sys_valid_o beat, then go to DRAIN.
- DRAIN: wait for sys_output_valid_i=1, then latch sys_output_i into an internal tile register and go to WRITE. A counter starts at 0 on DRAIN entry. If it reaches DRAIN_TIMEOUT without valid, set timeout_o and go to CLEAR, with no C writes.
- WRITE: row r=0..SYS_ARR_SIZE-1. c_we_o=1, c_addr_o=c_base+r, c_data_o=latched row r. The row advances only on a cycle where c_ready_i=1. Address and data hold stable while c_ready_i=0. After the last row is accepted, go to CLEAR.
- CLEAR: acc_clear_o=1 for one cycle, then go to DONE.
- DONE: done_o=1 for one cycle, then go to IDLE. busy_o falls in the same cycle done_o is high in IDLE' terms: busy_o=1 in DONE, 0 from the next cycle.
- Back-to-back operation: start_i arriving in the cycle after DONE (state IDLE) is accepted.
- Reset mid-operation returns to IDLE immediately. Any pending C write is dropped, and acc_clear_o is not issued.
- Latency (k_len=K, output valid immediately, c_ready_i=1): start to done_o = 1 (IDLE→FEED) + K + 1 + 1 + N + 1 + 1 cycles, where N=SYS_ARR_SIZE.

Test Plan:
- Reset → all outputs 0, busy_o=0. Assert rst_i asynchronously mid-FEED with k_len=8 → ab_en_o and sys_valid_o drop without a clock edge; next start_i is accepted normally.
- start_i, k_len=4, a_base=0x10, b_base=0x20, c_base=0x30; sys_output_valid_i rises 3 cycles after FLUSH; c_ready_i=1 →
  - a_addr_o sequence 0x10..0x13, b_addr_o 0x20..0x23;
  - sys_valid_o high for 4 cycles;
  - C writes to 0x30 and 0x31 with row0/row1 of the latched output;
  - one acc_clear_o pulse, then done_o.
- Same run with c_ready_i low for 2 cycles during row 0 → c_addr_o=0x30 and c_data_o held for 3 cycles; exactly 2 writes accepted.
- a_base=0x3FE, k_len=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- k_len=0 → done_o one cycle after start; ab_en_o, c_we_o and acc_clear_o never assert.
- sys_output_valid_i held low → timeout_o=1 after 64 DRAIN cycles, no c_we_o, acc_clear_o and done_o still pulse. A second start with valid data clears timeout_o; also check start_i pulses during WRITE are ignored.
